// File: rtl/quick_sort_engine.sv
// Iterative in-place quicksort over an internal array: explicit range stack,
// Lomuto partition, one compare/swap per clock.
module quick_sort_engine #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int STK_DEPTH = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 start,
  input  logic                 descending,
  input  logic [WORD_SIZE-1:0] lo,
  input  logic [WORD_SIZE-1:0] hi,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // state | meaning
  // IDLE  | waiting for start; host owns the array
  // CHECK | validate captured range, seed the stack
  // POP   | fetch next range or finish when stack empty
  // LDPIV | latch pivot = mem[h]
  // SCAN  | one j per cycle, swap keys on the pivot's side
  // FSWAP | move pivot into its final slot i
  // PUSH  | push sub-ranges of size >= 2, larger first
  // FIN   | one-cycle done pulse, release busy
  typedef enum logic [2:0] {IDLE, CHECK, POP, LDPIV, SCAN, FSWAP, PUSH, FIN} state_t;

  localparam int SP_W = $clog2(STK_DEPTH + 1);
  localparam int STK_N = 2 ** SP_W;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    stk_lo [STK_N];
  logic [ADDR_W-1:0]    stk_hi [STK_N];

  state_t               state;
  logic                 desc_q;
  logic [WORD_SIZE-1:0] lo_q, hi_q, pivot;
  logic [ADDR_W-1:0]    l_q, h_q, i_q, j_q;
  logic [SP_W-1:0]      sp;

  logic                 take;
  logic                 swap_en;
  logic [ADDR_W-1:0]    swap_b;
  logic [ADDR_W:0]      left_sz, right_sz;
  logic                 push_l, push_r, stk_ovf;
  logic [SP_W:0]        sp_next;

  always_comb begin
    take     = desc_q ? (mem[j_q] > pivot) : (mem[j_q] < pivot);
    swap_en  = ((state == SCAN) && take) || (state == FSWAP);
    swap_b   = (state == FSWAP) ? h_q : j_q;
    // i lies in [l,h] after partition, so neither difference can wrap
    left_sz  = {1'b0, i_q} - {1'b0, l_q};
    right_sz = {1'b0, h_q} - {1'b0, i_q};
    push_l   = left_sz >= (ADDR_W+1)'(2);
    push_r   = right_sz >= (ADDR_W+1)'(2);
    sp_next  = {1'b0, sp} + (SP_W+1)'(push_l) + (SP_W+1)'(push_r);
    stk_ovf  = sp_next > (SP_W+1)'(STK_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end else if (swap_en) begin
      mem[i_q]    <= mem[swap_b];
      mem[swap_b] <= mem[i_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
      desc_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      pivot   <= '0;
      l_q     <= '0;
      h_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      sp      <= '0;
      for (int k = 0; k < STK_N; k++) begin
        stk_lo[k] <= '0;
        stk_hi[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (!busy) rd_data <= mem[rd_addr];
      case (state)
        IDLE: begin
          if (start) begin
            lo_q   <= lo;
            hi_q   <= hi;
            desc_q <= descending;
            err    <= 1'b0;
            sp     <= '0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (hi_q >= WORD_SIZE'(DEPTH)) begin
            err   <= 1'b1;
            state <= FIN;
          end else if (lo_q >= hi_q) begin
            state <= FIN;
          end else begin
            stk_lo[0] <= lo_q[ADDR_W-1:0];
            stk_hi[0] <= hi_q[ADDR_W-1:0];
            sp        <= SP_W'(1);
            state     <= POP;
          end
        end
        POP: begin
          if (sp == '0) begin
            state <= FIN;
          end else begin
            sp    <= sp - SP_W'(1);
            l_q   <= stk_lo[sp - SP_W'(1)];
            h_q   <= stk_hi[sp - SP_W'(1)];
            i_q   <= stk_lo[sp - SP_W'(1)];
            j_q   <= stk_lo[sp - SP_W'(1)];
            state <= LDPIV;
          end
        end
        LDPIV: begin
          pivot <= mem[h_q];
          state <= SCAN;
        end
        SCAN: begin
          if (take) i_q <= i_q + ADDR_W'(1);
          if (j_q == h_q - ADDR_W'(1)) state <= FSWAP;
          else j_q <= j_q + ADDR_W'(1);
        end
        FSWAP: state <= PUSH;
        PUSH: begin
          if (stk_ovf) begin
            err   <= 1'b1;
            state <= FIN;
          end else begin
            // larger range goes deeper so the smaller one is partitioned next
            if (push_l && push_r) begin
              if (left_sz >= right_sz) begin
                stk_lo[sp]            <= l_q;
                stk_hi[sp]            <= i_q - ADDR_W'(1);
                stk_lo[sp + SP_W'(1)] <= i_q + ADDR_W'(1);
                stk_hi[sp + SP_W'(1)] <= h_q;
              end else begin
                stk_lo[sp]            <= i_q + ADDR_W'(1);
                stk_hi[sp]            <= h_q;
                stk_lo[sp + SP_W'(1)] <= l_q;
                stk_hi[sp + SP_W'(1)] <= i_q - ADDR_W'(1);
              end
            end else if (push_l) begin
              stk_lo[sp] <= l_q;
              stk_hi[sp] <= i_q - ADDR_W'(1);
            end else if (push_r) begin
              stk_lo[sp] <= i_q + ADDR_W'(1);
              stk_hi[sp] <= h_q;
            end
            sp    <= sp_next[SP_W-1:0];
            state <= POP;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_sort_engine.sv
// Directed bench for quick_sort_engine: per-scenario tasks with inline checks.
module tb_quick_sort_engine;

  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        start;
  logic        descending;
  logic [15:0] lo, hi;
  logic        busy, done, err;

  int checks = 0;
  int failures = 0;

  quick_sort_engine dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .descending(descending),
    .lo(lo), .hi(hi), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic write_word(input int a, input int d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = 16'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic read_word(input int a, output int v);
    rd_addr = 6'(a);
    @(posedge clk); #1;
    v = int'(rd_data);
  endtask

  task automatic run_sort(input int l, input int h, input bit d, output int cyc, output bit hold_ok);
    lo = 16'(l); hi = 16'(h); descending = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; hold_ok = 1'b1;
    while (!done && cyc < BUDGET) begin
      if (!busy) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    start = 1'b0; descending = 1'b0; lo = '0; hi = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ascending;
    int din[8] = '{5, 3, 8, 1, 9, 2, 7, 4};
    int exp_v[8] = '{1, 2, 3, 4, 5, 7, 8, 9};
    int cyc, v;
    bit hold;
    for (int k = 0; k < 8; k++) write_word(k, din[k]);
    run_sort(0, 7, 1'b0, cyc, hold);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL asc_done_timeout got=%b exp=1", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL asc_err got=%b exp=0", err); end
    checks++; if (!hold) begin failures++; $display("FAIL asc_busy_hold got=0 exp=1"); end
    for (int k = 0; k < 8; k++) begin
      read_word(k, v);
      checks++; if (v !== exp_v[k]) begin failures++; $display("FAIL asc_data[%0d] got=%0d exp=%0d", k, v, exp_v[k]); end
    end
  endtask

  task automatic test_descending;
    int din[8] = '{5, 3, 8, 1, 9, 2, 7, 4};
    int exp_v[8] = '{9, 8, 7, 5, 4, 3, 2, 1};
    int dup[4] = '{3, 3, 1, 3};
    int exp_d[4] = '{1, 3, 3, 3};
    int cyc, v;
    bit hold;
    for (int k = 0; k < 8; k++) write_word(k, din[k]);
    run_sort(0, 7, 1'b1, cyc, hold);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL desc_done_timeout got=%b exp=1", done); end
    for (int k = 0; k < 8; k++) begin
      read_word(k, v);
      checks++; if (v !== exp_v[k]) begin failures++; $display("FAIL desc_data[%0d] got=%0d exp=%0d", k, v, exp_v[k]); end
    end
    for (int k = 0; k < 4; k++) write_word(k, dup[k]);
    run_sort(0, 3, 1'b0, cyc, hold);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL dup_done_timeout got=%b exp=1", done); end
    for (int k = 0; k < 4; k++) begin
      read_word(k, v);
      checks++; if (v !== exp_d[k]) begin failures++; $display("FAIL dup_data[%0d] got=%0d exp=%0d", k, v, exp_d[k]); end
    end
  endtask

  task automatic test_subrange;
    int din[8] = '{9, 9, 4, 2, 6, 1, 0, 0};
    int exp_v[8] = '{9, 9, 1, 2, 4, 6, 0, 0};
    int cyc, v;
    bit hold;
    for (int k = 0; k < 8; k++) write_word(k, din[k]);
    run_sort(2, 5, 1'b0, cyc, hold);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL sub_done_timeout got=%b exp=1", done); end
    for (int k = 0; k < 8; k++) begin
      read_word(k, v);
      checks++; if (v !== exp_v[k]) begin failures++; $display("FAIL sub_data[%0d] got=%0d exp=%0d", k, v, exp_v[k]); end
    end
  endtask

  task automatic test_trivial_and_error;
    int exp_v[8] = '{9, 9, 1, 2, 4, 6, 0, 0};
    int cyc, v;
    bit hold;
    run_sort(4, 4, 1'b0, cyc, hold);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL single_done_cycle got=%0d exp=3", cyc); end
    checks++; if (!hold) begin failures++; $display("FAIL single_busy_hold got=0 exp=1"); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
    run_sort(0, 64, 1'b0, cyc, hold);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL range_done_cycle got=%0d exp=3", cyc); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL range_err got=%b exp=1", err); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL range_done_pulse got=%b exp=0", done); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL range_err_sticky got=%b exp=1", err); end
    for (int k = 0; k < 8; k++) begin
      read_word(k, v);
      checks++; if (v !== exp_v[k]) begin failures++; $display("FAIL trivial_data[%0d] got=%0d exp=%0d", k, v, exp_v[k]); end
    end
  endtask

  task automatic test_full_reverse;
    int cyc, v;
    bit hold;
    for (int k = 0; k < 64; k++) write_word(k, 63 - k);
    run_sort(0, 63, 1'b0, cyc, hold);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done_timeout got=%b exp=1", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_err got=%b exp=0", err); end
    checks++; if (!hold) begin failures++; $display("FAIL full_busy_hold got=0 exp=1"); end
    for (int k = 0; k < 64; k++) begin
      read_word(k, v);
      checks++; if (v !== k) begin failures++; $display("FAIL full_data[%0d] got=%0d exp=%0d", k, v, k); end
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, v;
    for (int k = 0; k < 64; k++) write_word(k, 63 - k);
    rd_addr = 6'd5; lo = 16'd0; hi = 16'd63; descending = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_cycle1 got=%b exp=1", busy); end
    checks++; if (rd_data !== 16'd58) begin failures++; $display("FAIL rd_capture got=%0d exp=58", rd_data); end
    rd_addr = 6'd10; wr_en = 1'b1; wr_addr = 6'd0; wr_data = 16'hBEEF;
    start = 1'b1; lo = 16'd4; hi = 16'd4;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rd_data !== 16'd58) begin failures++; $display("FAIL rd_frozen got=%0d exp=58", rd_data); end
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ignore_done_timeout got=%b exp=1", done); end
    for (int k = 0; k < 64; k++) begin
      read_word(k, v);
      checks++; if (v !== k) begin failures++; $display("FAIL ignore_data[%0d] got=%0d exp=%0d", k, v, k); end
    end
  endtask

  task automatic test_reset_mid_sort;
    int din[8] = '{5, 3, 8, 1, 9, 2, 7, 4};
    int exp_v[8] = '{1, 2, 3, 4, 5, 7, 8, 9};
    int cyc, v;
    bit hold;
    lo = 16'd0; hi = 16'd63; descending = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_next_cycle got busy=%b done=%b exp=0,0", busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) write_word(k, din[k]);
    run_sort(0, 7, 1'b0, cyc, hold);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL after_abort_timeout got=%b exp=1", done); end
    for (int k = 0; k < 8; k++) begin
      read_word(k, v);
      checks++; if (v !== exp_v[k]) begin failures++; $display("FAIL after_abort_data[%0d] got=%0d exp=%0d", k, v, exp_v[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_subrange();
    test_trivial_and_error();
    test_full_reverse();
    test_busy_ignore();
    test_reset_mid_sort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
